fft_sync_fifo: RTL and testbench

- Single-clock, first-word-fall-behind FIFO buffering 64-bit FFT sample words between producer and consumer stages of the spectrum-analyzer datapath.
- 2048 entries deep, with full/empty and programmable almost-full/almost-empty flags.
- Read data is unregistered beyond the RAM read: it is valid one clock after the accepted read.
- The block does not depend on any global-reset primitive; all state is cleared by its own reset port.

---
 rtl/fft_fifo_pkg.sv | 12 +
 rtl/fft_sync_fifo_if.sv | 23 ++
 rtl/fft_fifo_ram.sv | 21 ++
 rtl/fft_sync_fifo.sv | 70 +++++++
 tb/tb_fft_sync_fifo.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fft_fifo_pkg.sv
// Shared sizing for the FFT sample FIFO: depth, word width and flag thresholds.
package fft_fifo_pkg;
  localparam int DEPTH_WIDTH      = 11;
  localparam int DATA_WIDTH       = 64;
  localparam int DEPTH            = 2 ** DEPTH_WIDTH;
  localparam int ALMOST_FULL_NUM  = 2044;
  localparam int ALMOST_EMPTY_NUM = 4;

  // Pointer and occupancy share one width: wrap bit plus RAM address.
  typedef logic [DEPTH_WIDTH:0]   ptr_t;
  typedef logic [DATA_WIDTH-1:0]  word_t;
endpackage

// File: rtl/fft_sync_fifo_if.sv
// Producer/consumer handshake bundle for the FFT sample FIFO.
interface fft_sync_fifo_if;
  import fft_fifo_pkg::*;

  word_t wr_data;
  logic  wr_en;
  logic  wr_full;
  logic  almost_full;
  word_t rd_data;
  logic  rd_en;
  logic  rd_empty;
  logic  almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, almost_full, rd_data, rd_empty, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, almost_full, rd_data, rd_empty, almost_empty
  );
endinterface

// File: rtl/fft_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port; no reset so it maps to block RAM.
module fft_fifo_ram #(
  parameter int AW = 11,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // Read register only loads on an accepted read, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata      <= mem[raddr];
  end
endmodule

// File: rtl/fft_sync_fifo.sv
// 2048x64 single-clock FIFO; pointers, occupancy and registered flags around a block RAM.
module fft_sync_fifo
  import fft_fifo_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fft_sync_fifo_if.slave bus
);
  ptr_t  wptr, rptr, wptr_nxt, rptr_nxt;
  ptr_t  count, count_nxt;
  logic  full_q, empty_q, afull_q, aempty_q;
  logic  rd_seen;
  logic  wr_acc, rd_acc;
  word_t ram_q;

  // Acceptance uses registered flags only, keeping request-to-flag paths sequential.
  assign wr_acc = bus.wr_en & ~full_q;
  assign rd_acc = bus.rd_en & ~empty_q;

  always_comb begin
    wptr_nxt  = wptr + ptr_t'(wr_acc);
    rptr_nxt  = rptr + ptr_t'(rd_acc);
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ptr_t'(1);
      2'b01:   count_nxt = count - ptr_t'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      rd_seen  <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      count    <= count_nxt;
      empty_q  <= (wptr_nxt == rptr_nxt);
      full_q   <= (wptr_nxt[DEPTH_WIDTH] != rptr_nxt[DEPTH_WIDTH]) &&
                  (wptr_nxt[DEPTH_WIDTH-1:0] == rptr_nxt[DEPTH_WIDTH-1:0]);
      afull_q  <= (count_nxt >= ptr_t'(ALMOST_FULL_NUM));
      aempty_q <= (count_nxt <= ptr_t'(ALMOST_EMPTY_NUM));
      rd_seen  <= rd_seen | rd_acc;
    end
  end

  fft_fifo_ram #(.AW(DEPTH_WIDTH), .DW(DATA_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[DEPTH_WIDTH-1:0]),
    .wdata (bus.wr_data),
    .re    (rd_acc),
    .raddr (rptr[DEPTH_WIDTH-1:0]),
    .rdata (ram_q)
  );

  // RAM output has no reset; mask it to zero until the first read after reset.
  assign bus.rd_data      = rd_seen ? ram_q : '0;
  assign bus.wr_full      = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.rd_empty     = empty_q;
  assign bus.almost_empty = aempty_q;
endmodule

// File: tb/tb_fft_sync_fifo.sv
// Directed bench for fft_sync_fifo: reset, fill, drain, simultaneous traffic, wrap and mid-run reset.
module tb_fft_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fft_sync_fifo_if bus ();

  fft_sync_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // flag vector order: {wr_full, almost_full, rd_empty, almost_empty}
  logic [3:0] flags;
  assign flags = {bus.wr_full, bus.almost_full, bus.rd_empty, bus.almost_empty};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    #200;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    total++;
    if (flags !== 4'b0011) begin bad++; $display("FAIL reset_flags got=%b want=%b", flags, 4'b0011); end
    total++;
    if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data); end
  endtask

  task automatic test_fill;
    int cnt;
    logic [3:0] ef;
    for (int i = 0; i < 2049; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 64'hFFFF_FFFF_FFFF_FFFF - 64'(i);
      tick();
      cnt = (i + 1 > 2048) ? 2048 : i + 1;
      ef  = {cnt == 2048, cnt >= 2044, 1'b0, cnt <= 4};
      total++;
      if (flags !== ef) begin bad++; $display("FAIL fill_flags write=%0d got=%b want=%b", i + 1, flags, ef); end
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_drain;
    int rem;
    logic [3:0] ef;
    logic [63:0] ed;
    for (int i = 0; i < 2049; i++) begin
      bus.rd_en = 1'b1;
      tick();
      rem = (i >= 2047) ? 0 : 2047 - i;
      ed  = 64'hFFFF_FFFF_FFFF_FFFF - 64'((i < 2048) ? i : 2047);
      ef  = {1'b0, rem >= 2044, rem == 0, rem <= 4};
      total++;
      if (bus.rd_data !== ed) begin bad++; $display("FAIL drain_data read=%0d got=%h want=%h", i + 1, bus.rd_data, ed); end
      total++;
      if (flags !== ef) begin bad++; $display("FAIL drain_flags read=%0d got=%b want=%b", i + 1, flags, ef); end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_simultaneous;
    for (int k = 0; k < 10; k++) begin
      bus.wr_en = 1'b1; bus.wr_data = 64'hA000 + 64'(k); tick();
    end
    for (int j = 0; j < 100; j++) begin
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 64'hA000 + 64'(10 + j);
      tick();
      total++;
      if (bus.rd_data !== 64'hA000 + 64'(j)) begin bad++; $display("FAIL simul_data cyc=%0d got=%h want=%h", j, bus.rd_data, 64'hA000 + 64'(j)); end
      total++;
      if (flags !== 4'b0000) begin bad++; $display("FAIL simul_flags cyc=%0d got=%b want=0000", j, flags); end
    end
    bus.wr_en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      bus.rd_en = 1'b1; tick();
      total++;
      if (bus.rd_data !== 64'hA000 + 64'(100 + j)) begin bad++; $display("FAIL simul_tail cyc=%0d got=%h want=%h", j, bus.rd_data, 64'hA000 + 64'(100 + j)); end
    end
    bus.rd_en = 1'b0;
    total++;
    if (flags !== 4'b0011) begin bad++; $display("FAIL simul_empty got=%b want=0011", flags); end

    // fill to 2048, then write+read at full: only the read is taken
    for (int k = 0; k < 2048; k++) begin
      bus.wr_en = 1'b1; bus.wr_data = 64'hB000_0000 + 64'(k); tick();
    end
    total++;
    if (flags !== 4'b1100) begin bad++; $display("FAIL full_flags got=%b want=1100", flags); end
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 64'hDEAD;
    tick();
    total++;
    if (bus.rd_data !== 64'hB000_0000) begin bad++; $display("FAIL full_rw_data got=%h want=%h", bus.rd_data, 64'hB000_0000); end
    total++;
    if (flags !== 4'b0100) begin bad++; $display("FAIL full_rw_flags got=%b want=0100", flags); end
    bus.wr_en = 1'b0;
    for (int j = 0; j < 2047; j++) begin
      bus.rd_en = 1'b1; tick();
      total++;
      if (bus.rd_data !== 64'hB000_0000 + 64'(1 + j)) begin bad++; $display("FAIL full_drain read=%0d got=%h want=%h", j, bus.rd_data, 64'hB000_0000 + 64'(1 + j)); end
    end
    total++;
    if (flags !== 4'b0011) begin bad++; $display("FAIL full_drain_empty got=%b want=0011", flags); end

    // write+read at empty: only the write is taken, rd_data holds
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 64'hE000;
    tick();
    total++;
    if (flags !== 4'b0001) begin bad++; $display("FAIL empty_rw_flags got=%b want=0001", flags); end
    total++;
    if (bus.rd_data !== 64'hB000_07FF) begin bad++; $display("FAIL empty_rw_hold got=%h want=%h", bus.rd_data, 64'hB000_07FF); end
    bus.wr_en = 1'b0;
    tick();
    bus.rd_en = 1'b0;
    total++;
    if (bus.rd_data !== 64'hE000) begin bad++; $display("FAIL empty_rw_data got=%h want=E000", bus.rd_data); end
    total++;
    if (flags !== 4'b0011) begin bad++; $display("FAIL empty_rw_final got=%b want=0011", flags); end
  endtask

  task automatic test_wrap;
    int wn = 0;
    int rn = 0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 1500; k++) begin
        bus.wr_en = 1'b1; bus.wr_data = 64'hC000_0000 + 64'(wn); wn++; tick();
      end
      bus.wr_en = 1'b0;
      for (int k = 0; k < 1500; k++) begin
        bus.rd_en = 1'b1; tick();
        total++;
        if (bus.rd_data !== 64'hC000_0000 + 64'(rn)) begin bad++; $display("FAIL wrap_data word=%0d got=%h want=%h", rn, bus.rd_data, 64'hC000_0000 + 64'(rn)); end
        rn++;
      end
      bus.rd_en = 1'b0;
      total++;
      if (flags !== 4'b0011) begin bad++; $display("FAIL wrap_empty round=%0d got=%b want=0011", r, flags); end
    end
  endtask

  task automatic test_mid_reset;
    for (int k = 0; k < 1024; k++) begin
      bus.wr_en = 1'b1; bus.wr_data = 64'hD000 + 64'(k); tick();
    end
    bus.rd_en = 1'b1; tick();
    total++;
    if (flags !== 4'b0000) begin bad++; $display("FAIL half_flags got=%b want=0000", flags); end
    #3 rst = 1'b0;
    #1;
    total++;
    if (flags !== 4'b0011) begin bad++; $display("FAIL midrst_flags got=%b want=0011", flags); end
    total++;
    if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", bus.rd_data); end
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    rst = 1'b1;
    tick();
    bus.wr_en = 1'b1; bus.wr_data = 64'hF00D; tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b1; tick();
    bus.rd_en = 1'b0;
    total++;
    if (bus.rd_data !== 64'hF00D) begin bad++; $display("FAIL midrst_first got=%h want=F00D", bus.rd_data); end
    total++;
    if (flags !== 4'b0011) begin bad++; $display("FAIL midrst_final got=%b want=0011", flags); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
